// File: rtl/hex_display_scan.sv
// Four-digit multiplexed seven-segment scanner with blanking, blink
// and tear-free double-buffered updates applied at frame wrap.
module hex_display_scan #(
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex_0,
  input  logic [3:0] hex_1,
  input  logic [3:0] hex_2,
  input  logic [3:0] hex_3,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  input  logic       upd,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [3:0] blink;
    logic [3:0] dp;
    logic [3:0] h3;
    logic [3:0] h2;
    logic [3:0] h1;
    logic [3:0] h0;
  } disp_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          bph;
  disp_t         pend;
  disp_t         act;
  logic          pend_vld;
  disp_t         din;
  logic          tick;
  logic          wrap;
  logic [3:0]    cur_hex;
  logic          blank;
  logic [6:0]    nxt_seg;
  logic          nxt_dp;
  logic [3:0]    nxt_an;

  assign din  = '{blink: blink_mask, dp: dp_mask,
                  h3: hex_3, h2: hex_2, h1: hex_1, h0: hex_0};
  assign tick = (presc == P_LAST);
  assign wrap = tick && (idx == 2'd3);

  always_comb begin
    cur_hex = act.h0;
    unique case (idx)
      2'd0: cur_hex = act.h0;
      2'd1: cur_hex = act.h1;
      2'd2: cur_hex = act.h2;
      2'd3: cur_hex = act.h3;
    endcase
    blank   = bph & act.blink[idx];
    nxt_seg = blank ? 7'h7F : ~hex7(cur_hex);
    nxt_dp  = blank ? 1'b1 : ~act.dp[idx];
    nxt_an  = (presc < P_BLANK) ? 4'hF : ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
      bph  <= 1'b0;
    end else if (bcnt == B_LAST) begin
      bcnt <= '0;
      bph  <= ~bph;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // New data goes to pending; active only changes on the 3->0 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      act      <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (wrap && pend_vld) act <= pend;
      if (upd) begin
        pend     <= din;
        pend_vld <= 1'b1;
      end else if (wrap) begin
        pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= nxt_seg;
      dp_n       <= nxt_dp;
      an_n       <= nxt_an;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with a 4-cycle slot and
// 64-cycle blink; each frame is checked slot by slot.
module tb_hex_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hex_0 = '0;
  logic [3:0] hex_1 = '0;
  logic [3:0] hex_2 = '0;
  logic [3:0] hex_3 = '0;
  logic [3:0] blink_mask = '0;
  logic [3:0] dp_mask = '0;
  logic       upd = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       frame_done;

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;

  hex_display_scan #(
    .SCAN_DIV (4),
    .BLANK_CYC(1),
    .BLINK_DIV(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hex_0     (hex_0),
    .hex_1     (hex_1),
    .hex_2     (hex_2),
    .hex_3     (hex_3),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .upd       (upd),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_off(input string tag);
    n_chk += 4;
    if (seg_n !== 7'h7F) begin
      n_fail++;
      $display("FAIL %s seg_n: got %h want 7f", tag, seg_n);
    end
    if (dp_n !== 1'b1) begin
      n_fail++;
      $display("FAIL %s dp_n: got %b want 1", tag, dp_n);
    end
    if (an_n !== 4'hF) begin
      n_fail++;
      $display("FAIL %s an_n: got %h want f", tag, an_n);
    end
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_done: got %b want 0", tag, frame_done);
    end
  endtask

  // segs = {d3,d2,d1,d0} expected seg_n; dpn = expected dp_n per digit.
  task automatic frame(input string tag, input logic [27:0] segs,
                       input logic [3:0] dpn,
                       input int u0, input logic [23:0] d0,
                       input int u1, input logic [23:0] d1);
    int p, k;
    logic [3:0] ean;
    logic       efd;
    for (int i = 0; i < 16; i++) begin
      if (i == u0) begin
        {blink_mask, dp_mask, hex_3, hex_2, hex_1, hex_0} = d0;
        upd = 1'b1;
      end else if (i == u1) begin
        {blink_mask, dp_mask, hex_3, hex_2, hex_1, hex_0} = d1;
        upd = 1'b1;
      end
      @(posedge clk);
      #1;
      upd = 1'b0;
      n++;
      p   = (n - 1) % 4;
      k   = ((n - 1) / 4) % 4;
      ean = (p == 0) ? 4'hF : ~(4'b0001 << k);
      efd = (n % 16 == 0);
      n_chk += 2;
      if (an_n !== ean) begin
        n_fail++;
        $display("FAIL %s an_n n=%0d: got %h want %h", tag, n, an_n, ean);
      end
      if (frame_done !== efd) begin
        n_fail++;
        $display("FAIL %s frame_done n=%0d: got %b want %b",
                 tag, n, frame_done, efd);
      end
      if (p != 0) begin
        n_chk += 2;
        if (seg_n !== segs[k*7 +: 7]) begin
          n_fail++;
          $display("FAIL %s seg_n n=%0d dig=%0d: got %h want %h",
                   tag, n, k, seg_n, segs[k*7 +: 7]);
        end
        if (dp_n !== dpn[k]) begin
          n_fail++;
          $display("FAIL %s dp_n n=%0d dig=%0d: got %b want %b",
                   tag, n, k, dp_n, dpn[k]);
        end
      end
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1 check_off("reset_async");
    repeat (2) @(posedge clk);
    #1 check_off("reset_held");
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_scan;
    frame("scan0", {4{7'h40}}, 4'hF, -1, '0, -1, '0);
    frame("scan1", {4{7'h40}}, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_update;
    frame("upd_old", {4{7'h40}}, 4'hF, 5, 24'h001234, -1, '0);
    frame("upd_new", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_double_upd;
    frame("dbl_old", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF,
          2, 24'h005555, 9, 24'h009999);
    frame("dbl_new", {4{7'h10}}, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_back_to_back;
    frame("wrap_a", {4{7'h10}}, 4'hF, 3, 24'h007777, 15, 24'h00AAAA);
    frame("wrap_b", {4{7'h78}}, 4'hF, -1, '0, -1, '0);
    frame("wrap_c", {4{7'h08}}, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_blink;
    logic ph;
    frame("blink_ld", {4{7'h08}}, 4'hF, 0, 24'h120008, -1, '0);
    for (int f = 0; f < 8; f++) begin
      ph = ((n / 16) / 4) % 2 == 1;
      frame(ph ? "blink_on" : "blink_off",
            {7'h40, 7'h40, 7'h40, ph ? 7'h7F : 7'h00},
            4'b1101, -1, '0, -1, '0);
    end
  endtask

  task automatic test_rst_pending;
    {blink_mask, dp_mask, hex_3, hex_2, hex_1, hex_0} = 24'h008888;
    upd = 1'b1;
    @(posedge clk);
    #1 upd = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_off("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    frame("post_rst0", {4{7'h40}}, 4'hF, -1, '0, -1, '0);
    frame("post_rst1", {4{7'h40}}, 4'hF, -1, '0, -1, '0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_update();
    test_double_upd();
    test_back_to_back();
    test_blink();
    test_rst_pending();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
